// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath mux selects and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDI_EX, S_ADDI_WB,
    S_TRAP
  } state_t;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // States that own the memory port and therefore wait on mem_ready.
  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface mips_multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 alu_zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [1:0]           pc_source;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           reg_dst;
  logic [1:0]           mem_to_reg;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 arith;
  logic [CNT_WIDTH-1:0] retired;
  logic                 trap;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, arith, retired, trap
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, arith, retired, trap
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Moore decode of the controller state into the datapath control word.
// Only the FETCH write strobes look at mem_ready, so IR/PC load with the data.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  // State -> control word lookup; anything not listed stays idle.
  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      S_FETCH: begin
        o_ctrl.i_or_d    = 1'b0;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = ALUB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCS_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = ALUB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.i_or_d   = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_dst    = RDST_RT;
        o_ctrl.mem_to_reg = M2R_MDR;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_RT;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_dst    = RDST_RD;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = ALUB_RT;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCS_JUMP;
        o_ctrl.reg_dst    = RDST_RA;
        o_ctrl.mem_to_reg = M2R_PC;
        o_ctrl.reg_write  = 1'b1;
      end
      S_JR: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCS_RS;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_dst    = RDST_RT;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: next-state dispatch, memory wait
// timeout, retired-instruction counter, and reset gating of all strobes.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WAIT_W-1:0]    r_wait;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 w_retire;
  logic                 w_waiting;
  logic                 w_timeout;
  ctrl_t                w_ctrl;

  assign w_waiting = is_mem_wait(r_state);
  // A completing access always wins over the timeout on the same cycle.
  assign w_timeout = w_waiting && !bus.mem_ready && (r_wait == WAIT_W'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state dispatch and retire pulse on leaving an instruction's last state.
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)          w_state_nxt = S_TRAP;
        else if (bus.mem_ready) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_state_nxt = S_MEM_ADDR;
          OP_RTYPE:     w_state_nxt = (bus.funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_BEQ:       w_state_nxt = S_BRANCH;
          OP_J:         w_state_nxt = S_JUMP;
          OP_JAL:       w_state_nxt = S_JAL;
          OP_ADDI:      w_state_nxt = S_ADDI_EX;
          default:      w_state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_state_nxt = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (w_timeout)          w_state_nxt = S_TRAP;
        else if (bus.mem_ready) w_state_nxt = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        if (w_timeout) begin
          w_state_nxt = S_TRAP;
        end else if (bus.mem_ready) begin
          w_state_nxt = S_FETCH;
          w_retire    = 1'b1;
        end
      end
      S_EXECUTE: w_state_nxt = S_R_WB;
      S_ADDI_EX: w_state_nxt = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDI_WB: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      default: w_state_nxt = S_TRAP;
    endcase
  end

  // Memory wait counter: counts stalled cycles, cleared on any other cycle.
  always_ff @(posedge clk) begin
    if (reset)                                       r_wait <= '0;
    else if (w_waiting && !bus.mem_ready && !w_timeout) r_wait <= r_wait + WAIT_W'(1);
    else                                             r_wait <= '0;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)         r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_WIDTH'(1);
  end

  mips_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Strobes are forced low while reset is held so an interrupted access writes nothing.
  assign bus.pc_write      = w_ctrl.pc_write      & ~reset;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond & ~reset;
  assign bus.mem_read      = w_ctrl.mem_read      & ~reset;
  assign bus.mem_write     = w_ctrl.mem_write     & ~reset;
  assign bus.ir_write      = w_ctrl.ir_write      & ~reset;
  assign bus.reg_write     = w_ctrl.reg_write     & ~reset;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.arith         = 1'b1;
  assign bus.retired       = r_retired;
  assign bus.trap          = (r_state == S_TRAP);

endmodule
